// File: rtl/shift_arb.sv
// Two-port round-robin arbiter in front of one 32-bit shifter with a single
// registered response slot (1-cycle latency, full throughput on back-to-back takes).
module shift_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [1:0]  op0,
    input  logic [4:0]  shamt0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [1:0]  op1,
    input  logic [4:0]  shamt1,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    logic        last_gnt;
    logic        can_accept;
    logic        pick0;
    logic [1:0]  sel_op;
    logic [4:0]  sel_shamt;
    logic [31:0] sel_data;
    logic [31:0] result;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // Port 0 wins when alone, or under contention when port 1 was granted last.
    assign pick0 = req0 && (!req1 || last_gnt);
    assign gnt0  = rst_n && can_accept && pick0;
    assign gnt1  = rst_n && can_accept && req1 && !pick0;

    assign sel_op    = gnt1 ? op1    : op0;
    assign sel_shamt = gnt1 ? shamt1 : shamt0;
    assign sel_data  = gnt1 ? data1  : data0;

    always_comb begin
        result = sel_data;
        case (sel_op)
            2'b00:   result = sel_data << sel_shamt;
            2'b01:   result = sel_data >> sel_shamt;
            2'b10:   result = $unsigned($signed(sel_data) >>> sel_shamt);
            default: result = sel_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            rsp_id   <= 1'b0;
            rsp_data <= 32'd0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (gnt0 || gnt1) begin
                        state    <= FULL;
                        rsp_id   <= gnt1;
                        rsp_data <= result;
                        last_gnt <= gnt1;
                    end
                end
                FULL: begin
                    if (gnt0 || gnt1) begin
                        rsp_id   <= gnt1;
                        rsp_data <= result;
                        last_gnt <= gnt1;
                    end else if (rsp_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 The block SHALL have the ports below.
- clk        input   1   single clock; all state updates on rising edge
- rst_n      input   1   reset, asynchronous assert, active-low
- req0       input   1   requester 0 has a shift operation pending
- op0        input   2   requester 0 operation: 00 SLL, 01 SRL, 10 SRA, 11 pass
- shamt0     input   5   requester 0 shift amount
- data0      input   32  requester 0 operand
- req1, op1, shamt1, data1   input  1/2/5/32   requester 1, same meaning as port 0
- gnt0       output  1   requester 0 operation accepted this cycle
- gnt1       output  1   requester 1 operation accepted this cycle
- rsp_valid  output  1   registered result available
- rsp_id     output  1   requester that owns rsp_data (0 or 1)
- rsp_data   output  32  shift result
- rsp_ready  input   1   consumer takes the result this cycle

REQ-002 The block SHALL have no parameters; widths are fixed as listed.

Function
REQ-003 The block SHALL share one 32-bit shifter between two requesters and give round-robin access.
REQ-004 Operations SHALL be:
- SLL: data << shamt, zero fill.
- SRL: data >> shamt, zero fill.
- SRA: data >> shamt, sign fill from data[31].
- 11: data unchanged.
REQ-005 shamt 0 SHALL return data unchanged for every op; shamt 31 SHALL be legal.
REQ-006 can_accept SHALL be true when rsp_valid=0 or (rsp_valid=1 and rsp_ready=1).
REQ-007 gntN SHALL be combinational: asserted only when reqN=1, can_accept=1 and port N wins arbitration.
REQ-008 At most one of gnt0 and gnt1 SHALL be high in any cycle.
REQ-009 Arbitration rules:
- Only one req high: that port wins.
- Both high: the port not granted most recently (last_gnt pointer) wins.
REQ-010 last_gnt SHALL update only on a cycle with a grant; it holds otherwise.
REQ-011 A requester SHALL hold reqN, opN, shamtN and dataN stable until the cycle gntN=1; a grant consumes exactly one operation.
REQ-012 Latency SHALL be 1 cycle. On the grant edge, rsp_data is loaded with the shifted result, rsp_id with the granted port, and rsp_valid is set.
REQ-013 Response stall:
- While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_data SHALL hold.
- While stalled, no grant SHALL occur.
REQ-014 Back-to-back: rsp_valid=1, rsp_ready=1 and a grant in the same cycle SHALL replace the response on the next edge with rsp_valid staying 1, giving full throughput of one operation per cycle.
REQ-015 rsp_valid=1, rsp_ready=1 and no request SHALL clear rsp_valid on the next edge.
REQ-016 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-017 Control states:
- EMPTY (rsp_valid=0) goes to FULL on a grant.
- FULL goes to EMPTY on take with no grant.
- FULL stays FULL on a stall or on take with a grant.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for clk, set:
- rsp_valid=0, rsp_id=0, rsp_data=0.
- last_gnt=1, so port 0 wins the first contention.
REQ-019 While rst_n=0, gnt0 and gnt1 SHALL be 0.
REQ-020 Reset asserted with a response pending SHALL discard that response; the requester is not re-granted.
REQ-021 After deassertion the first grant SHALL be possible on the first rising edge at which rst_n=1.

Verification
REQ-022 Single op: req0=1, op0=01, shamt0=4, data0=0xF0000000, rsp_ready=1. Required response: gnt0=1 in cycle N; rsp_valid=1, rsp_id=0, rsp_data=0x0F000000 in N+1.
REQ-023 SRA and SLL edges:
- op=10, shamt=31, data=0x80000000 gives 0xFFFFFFFF.
- op=00, shamt=31, data=0x00000003 gives 0x80000000.
- op=11, shamt=7 gives data unchanged.
REQ-024 Contention after reset: req0=req1=1 held, rsp_ready=1. Required grants: cycle 0 gnt0, then gnt1, gnt0, gnt1; rsp_id alternates 0,1,0,1 one cycle later; one result per cycle.
REQ-025 Stall: response pending, rsp_ready=0 for 3 cycles, req1=1. Required: gnt1=0 and rsp_data stable for 3 cycles; gnt1=1 in the cycle rsp_ready rises; the new result appears the next cycle.
REQ-026 Reset mid-operation: rst_n to 0 asynchronously while rsp_valid=1. Required: rsp_valid=0 before the next clk edge; after release, first contention grants port 0.
